// File: rtl/oled_screen_scheduler_pkg.sv
// oled_screen_scheduler_pkg
// Shared constants and types for the OLED screen scheduler and its helpers.
//   OLED_WIDTH / OLED_HEIGHT / OLED_PIXELS : panel geometry (96x64)
//   COLOR_BLACK                            : RGB565 black
//   sched_state_t                          : scheduler state encoding
//   step_src()                             : next/previous source with wraparound
package oled_screen_scheduler_pkg;

   localparam int          OLED_WIDTH  = 96;
   localparam int          OLED_HEIGHT = 64;
   localparam int          OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;
   localparam logic [15:0] COLOR_BLACK = 16'h0000;

   typedef enum logic [1:0] {
      SHOW    = 2'd0,
      PENDING = 2'd1,
      BLANK   = 2'd2
   } sched_state_t;

   // Step one source forward (fwd=1) or backward (fwd=0), wrapping in 0..num_src-1.
   function automatic logic [2:0] step_src(input logic [2:0] base,
                                           input logic       fwd,
                                           input int         num_src);
      int nxt;
      if (fwd) nxt = (int'(base) + 1) % num_src;
      else     nxt = (int'(base) + num_src - 1) % num_src;
      return 3'(nxt);
   endfunction

endpackage

// File: rtl/oled_screen_scheduler_xy_decode.sv
// oled_xy_decode
// Splits the OLED driver's linear pixel_index into column/row coordinates.
//   pixel_index : linear index from the OLED driver (row-major)
//   x           : column, pixel_index mod WIDTH (0 when out of range)
//   y           : row, pixel_index / WIDTH (0 when out of range)
//   in_range    : pixel_index < WIDTH*HEIGHT
module oled_xy_decode
   import oled_screen_scheduler_pkg::*;
#(
   parameter int WIDTH  = OLED_WIDTH,
   parameter int HEIGHT = OLED_HEIGHT
) (
   input  logic [12:0] pixel_index,
   output logic [6:0]  x,
   output logic [6:0]  y,
   output logic        in_range
);

   int idx;

   always_comb begin
      idx      = int'(pixel_index);
      in_range = (idx < WIDTH * HEIGHT);
      if (in_range) begin
         x = 7'(idx % WIDTH);
         y = 7'(idx / WIDTH);
      end else begin
         x = '0;
         y = '0;
      end
   end

endmodule

// File: rtl/oled_screen_scheduler.sv
// oled_screen_scheduler
// Shares one 96x64 OLED pixel stream between NUM_SRC renderers. Every screen
// change waits for a frame boundary, then shows one full black frame, then
// switches on the following frame boundary.
//   clock, reset    : pixel clock, asynchronous active-high reset
//   frame_begin     : one-cycle pulse at the start of each frame
//   pixel_index     : current pixel from the OLED driver
//   btn_next/prev   : single-cycle screen change requests
//   demo_en         : auto-cycle through screens every DEMO_FRAMES frames
//   render_data     : packed renderer outputs, source k at [16k+15:16k]
//   x, y            : decoded coordinates shared by all renderers
//   oled_data       : selected pixel, registered (1-cycle latency)
//   active_src      : source currently on screen
//   switching       : a screen change is in progress
module oled_screen_scheduler
   import oled_screen_scheduler_pkg::*;
#(
   parameter int NUM_SRC     = 4,
   parameter int DEFAULT_SRC = 0,
   parameter int DEMO_FRAMES = 120,
   parameter int WIDTH       = OLED_WIDTH,
   parameter int HEIGHT      = OLED_HEIGHT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  frame_begin,
   input  logic [12:0]           pixel_index,
   input  logic                  btn_next,
   input  logic                  btn_prev,
   input  logic                  demo_en,
   input  logic [NUM_SRC*16-1:0] render_data,
   output logic [6:0]            x,
   output logic [6:0]            y,
   output logic [15:0]           oled_data,
   output logic [2:0]            active_src,
   output logic                  switching
);

   localparam int CNT_W = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;

   sched_state_t     state;
   logic [2:0]       target;
   logic [CNT_W-1:0] demo_cnt;
   logic             in_range;
   logic [15:0]      sel_data;
   logic [2:0]       base;
   logic             manual;
   logic             cnt_last;
   logic             demo_fire;
   logic             req_valid;
   logic [2:0]       req_src;

   oled_xy_decode #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_xy (
      .pixel_index (pixel_index),
      .x           (x),
      .y           (y),
      .in_range    (in_range)
   );

   always_comb begin
      sel_data = COLOR_BLACK;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (active_src == 3'(k)) sel_data = render_data[16*k +: 16];
      end
   end

   // While a change is in flight, further presses step from the pending
   // target rather than from what is on screen, so repeated presses accumulate.
   always_comb begin
      base      = (state == SHOW) ? active_src : target;
      manual    = btn_next ^ btn_prev;
      cnt_last  = (demo_cnt == CNT_W'(DEMO_FRAMES - 1));
      demo_fire = (state == SHOW) && demo_en && frame_begin && cnt_last;
      req_valid = manual | demo_fire;
      req_src   = step_src(base, manual ? btn_next : 1'b1, NUM_SRC);
   end

   // Demo counter only advances while a screen is steadily shown; the frame
   // boundary that ends a blank frame is not counted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         demo_cnt <= '0;
      end else if (manual || !demo_en) begin
         demo_cnt <= '0;
      end else if (state == SHOW && frame_begin) begin
         demo_cnt <= cnt_last ? '0 : demo_cnt + CNT_W'(1);
      end
   end

   // A request taken in SHOW always passes through PENDING first, so the
   // current screen gets at least one complete frame before blanking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= SHOW;
         target     <= 3'(DEFAULT_SRC);
         active_src <= 3'(DEFAULT_SRC);
         switching  <= 1'b0;
      end else begin
         case (state)
            SHOW: begin
               if (req_valid) begin
                  target    <= req_src;
                  state     <= PENDING;
                  switching <= 1'b1;
               end
            end
            PENDING: begin
               if (req_valid) target <= req_src;
               if (frame_begin) state <= BLANK;
            end
            BLANK: begin
               if (req_valid) target <= req_src;
               if (frame_begin) begin
                  active_src <= req_valid ? req_src : target;
                  state      <= SHOW;
                  switching  <= 1'b0;
               end
            end
            default: begin
               state     <= SHOW;
               switching <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         oled_data <= COLOR_BLACK;
      end else if (state == BLANK || !in_range) begin
         oled_data <= COLOR_BLACK;
      end else begin
         oled_data <= sel_data;
      end
   end

endmodule

// File: tb/tb_oled_screen_scheduler.sv
// tb_oled_screen_scheduler
// Bench for oled_screen_scheduler: acts as the OLED driver (short frames),
// runs directed scenarios with literal expectations, then random traffic,
// while a behavioural model checks every output every cycle.
`timescale 1ns/1ps
module tb_oled_screen_scheduler;

   localparam int NUM_SRC     = 4;
   localparam int DEFAULT_SRC = 0;
   localparam int DEMO_FRAMES = 3;
   localparam int WIDTH       = 96;
   localparam int HEIGHT      = 64;

   logic                  clock       = 1'b0;
   logic                  reset       = 1'b1;
   logic                  frame_begin = 1'b0;
   logic [12:0]           pixel_index = '0;
   logic                  btn_next    = 1'b0;
   logic                  btn_prev    = 1'b0;
   logic                  demo_en     = 1'b0;
   logic [NUM_SRC*16-1:0] render_data = 64'h4444_3333_2222_1111;
   logic [6:0]            x;
   logic [6:0]            y;
   logic [15:0]           oled_data;
   logic [2:0]            active_src;
   logic                  switching;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   oled_screen_scheduler #(
      .NUM_SRC     (NUM_SRC),
      .DEFAULT_SRC (DEFAULT_SRC),
      .DEMO_FRAMES (DEMO_FRAMES),
      .WIDTH       (WIDTH),
      .HEIGHT      (HEIGHT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .frame_begin (frame_begin),
      .pixel_index (pixel_index),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .demo_en     (demo_en),
      .render_data (render_data),
      .x           (x),
      .y           (y),
      .oled_data   (oled_data),
      .active_src  (active_src),
      .switching   (switching)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the screen shown, the wanted screen, and how many
   // frame boundaries remain before the change lands (2 = still showing old
   // screen, 1 = blank frame, 0 = idle).
   int m_shown = DEFAULT_SRC;
   int m_want  = DEFAULT_SRC;
   int m_left  = 0;
   int m_cnt   = 0;
   int m_data  = 0;

   always @(posedge clock) begin : model
      int  base;
      int  req;
      int  ex;
      int  ey;
      bit  manual;
      bit  fire;
      bit  has_req;
      if (reset) begin
         m_shown = DEFAULT_SRC;
         m_want  = DEFAULT_SRC;
         m_left  = 0;
         m_cnt   = 0;
         m_data  = 0;
      end else begin
         if (m_left == 1 || int'(pixel_index) >= WIDTH * HEIGHT) m_data = 0;
         else m_data = int'(render_data[16*m_shown +: 16]);
         manual  = btn_next ^ btn_prev;
         base    = (m_left == 0) ? m_shown : m_want;
         fire    = (m_left == 0) && demo_en && frame_begin && (m_cnt == DEMO_FRAMES - 1);
         has_req = manual || fire;
         if (manual && btn_prev) req = (base + NUM_SRC - 1) % NUM_SRC;
         else                    req = (base + 1) % NUM_SRC;
         if (!demo_en || manual) m_cnt = 0;
         else if (m_left == 0 && frame_begin) m_cnt = (m_cnt == DEMO_FRAMES - 1) ? 0 : m_cnt + 1;
         if (m_left == 0) begin
            if (has_req) begin
               m_want = req;
               m_left = 2;
            end
         end else begin
            if (has_req) m_want = req;
            if (frame_begin) begin
               m_left--;
               if (m_left == 0) m_shown = m_want;
            end
         end
      end
      #1;
      if (int'(pixel_index) < WIDTH * HEIGHT) begin
         ex = int'(pixel_index) % WIDTH;
         ey = int'(pixel_index) / WIDTH;
      end else begin
         ex = 0;
         ey = 0;
      end
      check("model_x", int'(x), ex);
      check("model_y", int'(y), ey);
      check("model_oled_data", int'(oled_data), m_data);
      check("model_active_src", int'(active_src), m_shown);
      check("model_switching", int'(switching), (m_left != 0) ? 1 : 0);
   end

   // Driver-side frame generator.
   int fcnt         = 0;
   int flen         = 32;
   int pix          = 0;
   int pix_override = -1;
   bit rand_pix     = 1'b0;

   task automatic adv();
      if (fcnt >= flen - 1) begin
         fcnt        = 0;
         frame_begin = 1'b1;
         pix         = 0;
         if (rand_pix) flen = $urandom_range(40, 8);
      end else begin
         fcnt++;
         frame_begin = 1'b0;
         pix++;
      end
      if (pix_override >= 0) pixel_index = 13'(pix_override);
      else if (rand_pix && $urandom_range(7) == 0) pixel_index = 13'($urandom_range(8191));
      else pixel_index = 13'(pix);
   endtask

   task automatic cyc(input bit bn, input bit bp);
      @(negedge clock);
      btn_next = bn;
      btn_prev = bp;
      adv();
   endtask

   // Returns with frame_begin driven but not yet clocked in.
   task automatic to_fb();
      int n;
      n = 0;
      do begin
         cyc(1'b0, 1'b0);
         n++;
      end while (!frame_begin && n < 200);
      if (!frame_begin) check("frame_begin_timeout", 0, 1);
   endtask

   task automatic finish_switch();
      to_fb();
      cyc(1'b0, 1'b0);
      to_fb();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clock);
      check("reset_active_src", int'(active_src), 0);
      check("reset_switching", int'(switching), 0);
      check("reset_oled_data", int'(oled_data), 0);
      reset = 1'b0;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("first_pixel", int'(oled_data), 16'h1111);

      // Next: old screen until frame boundary, one black frame, then source 1
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      check("next_switching", int'(switching), 1);
      to_fb();
      check("next_old_data", int'(oled_data), 16'h1111);
      cyc(1'b0, 1'b0);
      check("next_pending_data", int'(oled_data), 16'h1111);
      cyc(1'b0, 1'b0);
      check("next_blank_data", int'(oled_data), 0);
      to_fb();
      check("next_blank_end", int'(oled_data), 0);
      check("next_blank_active", int'(active_src), 0);
      cyc(1'b0, 1'b0);
      check("next_active", int'(active_src), 1);
      check("next_done", int'(switching), 0);
      cyc(1'b0, 1'b0);
      check("next_data", int'(oled_data), 16'h2222);

      // Prev from 0 wraps to 3; both buttons together do nothing
      do_reset();
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      check("prev_switching", int'(switching), 1);
      finish_switch();
      check("prev_active", int'(active_src), 3);
      check("prev_data", int'(oled_data), 16'h4444);
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      check("both_no_switch", int'(switching), 0);
      check("both_active", int'(active_src), 3);

      // Reset during the blank frame
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      to_fb();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("blank_before_reset", int'(switching), 1);
      reset = 1'b1;
      #1;
      check("midreset_active", int'(active_src), 0);
      check("midreset_switching", int'(switching), 0);
      check("midreset_data", int'(oled_data), 0);
      @(negedge clock);
      reset = 1'b0;

      // Three nexts across PENDING/BLANK collapse into one blank frame
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      to_fb();
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      check("triple_in_blank", int'(switching), 1);
      to_fb();
      cyc(1'b0, 1'b0);
      check("triple_done", int'(switching), 0);
      check("triple_active", int'(active_src), 3);
      cyc(1'b0, 1'b0);
      check("triple_data", int'(oled_data), 16'h4444);

      // Next then prev returns to the same screen but still blanks
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      check("noop_switching", int'(switching), 1);
      to_fb();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("noop_blank", int'(oled_data), 0);
      to_fb();
      cyc(1'b0, 1'b0);
      check("noop_active", int'(active_src), 3);
      check("noop_done", int'(switching), 0);

      // Demo mode: request on the third frame boundary in SHOW
      do_reset();
      demo_en = 1'b1;
      to_fb();
      cyc(1'b0, 1'b0);
      check("demo_fb1", int'(switching), 0);
      to_fb();
      cyc(1'b0, 1'b0);
      check("demo_fb2", int'(switching), 0);
      to_fb();
      cyc(1'b0, 1'b0);
      check("demo_fb3", int'(switching), 1);
      to_fb();
      cyc(1'b0, 1'b0);
      to_fb();
      cyc(1'b0, 1'b0);
      check("demo_active", int'(active_src), 1);
      to_fb();
      cyc(1'b0, 1'b0);
      to_fb();
      cyc(1'b0, 1'b0);
      @(negedge clock);
      demo_en = 1'b0;
      cyc(1'b0, 1'b0);
      demo_en = 1'b1;
      to_fb();
      cyc(1'b0, 1'b0);
      to_fb();
      cyc(1'b0, 1'b0);
      check("demo_cleared", int'(switching), 0);
      to_fb();
      cyc(1'b0, 1'b0);
      check("demo_refire", int'(switching), 1);
      demo_en = 1'b0;
      to_fb();
      cyc(1'b0, 1'b0);
      to_fb();
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      check("demo_active2", int'(active_src), 2);
      check("demo_data2", int'(oled_data), 16'h3333);

      // Coordinate decode and out-of-range blanking
      pix_override = 95;
      cyc(1'b0, 1'b0);
      #1;
      check("x_95", int'(x), 95);
      check("y_95", int'(y), 0);
      pix_override = 96;
      cyc(1'b0, 1'b0);
      #1;
      check("x_96", int'(x), 0);
      check("y_96", int'(y), 1);
      pix_override = 6143;
      cyc(1'b0, 1'b0);
      #1;
      check("x_6143", int'(x), 95);
      check("y_6143", int'(y), 63);
      pix_override = 7000;
      cyc(1'b0, 1'b0);
      #1;
      check("x_7000", int'(x), 0);
      check("y_7000", int'(y), 0);
      check("data_6143", int'(oled_data), 16'h3333);
      cyc(1'b0, 1'b0);
      check("data_7000", int'(oled_data), 0);
      pix_override = -1;

      // Random traffic, checked by the model every cycle
      rand_pix = 1'b1;
      demo_en  = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         if (reset) reset = 1'b0;
         else if ($urandom_range(600) == 0) reset = 1'b1;
         btn_next = ($urandom_range(15) == 0);
         btn_prev = ($urandom_range(15) == 0);
         if ($urandom_range(200) == 0) demo_en = ~demo_en;
         if ($urandom_range(3) == 0) render_data = {$urandom, $urandom};
         adv();
      end
      @(negedge clock);
      reset    = 1'b0;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (3) @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
